// File: rtl/counter_pkg.sv
// Shared types and constants for the counter controller slice.
package counter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        UP     = 3'd2,
        DOWN   = 3'd3,
        FINISH = 3'd4
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int   CNT_W  = 16;

    // States in which the prescaler runs and the datapath may step
    function automatic logic is_counting(input state_e s);
        return (s == UP) || (s == DOWN);
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Request/status interface between the user side and counter_ctrl.
// With PAUSE_EN defined an extra pause request is carried.
interface counter_ctrl_if #(
    parameter int SWEEP_W = 8
) ();

`ifdef PAUSE_EN
    logic               pause;
`endif
    logic               start;
    logic               stop;
    logic               mode;
    logic [SWEEP_W-1:0] sweeps;
    logic               busy;
    logic               done;
    logic               dir;

    modport master (
`ifdef PAUSE_EN
        output pause,
`endif
        output start, stop, mode, sweeps,
        input  busy, done, dir
    );

    modport slave (
`ifdef PAUSE_EN
        input  pause,
`endif
        input  start, stop, mode, sweeps,
        output busy, done, dir
    );

endinterface

// File: rtl/counter_ctrl_tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count
// as the step tick; clr forces the count back to zero.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1'b1);

    logic [CW-1:0] cnt_r;

    // Prescale counter: cleared on request, frozen while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (clr) begin
            cnt_r <= ZERO;
        end else if (en) begin
            cnt_r <= (cnt_r == LAST) ? ZERO : cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequences the 16-bit up/down counter datapath from start/stop
// requests and the z/m limit flags. Optional macro PAUSE_EN adds a pause input.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int SWEEP_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    counter_ctrl_if.slave req,
    input  logic          z,
    input  logic          m,
    output logic          op,
    output logic          c_ld,
    output logic          c_clr
);

    localparam logic [SWEEP_W-1:0] SWEEP_ZERO = {SWEEP_W{1'b0}};
    localparam logic [SWEEP_W-1:0] SWEEP_ONE  = SWEEP_W'(1'b1);

    state_e             state_r;
    state_e             state_next_s;
    logic               mode_r;
    logic               mode_next_s;
    logic [SWEEP_W-1:0] left_r;
    logic [SWEEP_W-1:0] left_next_s;
    logic               busy_r;
    logic               done_r;
    logic               dir_r;
    logic               pause_s;
    logic               cnt_en_s;
    logic               pre_clr_s;
    logic               tick_s;
    logic               op_s;
    logic               c_ld_s;
    logic               c_clr_s;

`ifdef PAUSE_EN
    assign pause_s = req.pause;
`else
    assign pause_s = 1'b0;
`endif

    // Prescaler restarts on every state change so each phase begins a full period
    assign cnt_en_s  = is_counting(state_r) && !pause_s;
    assign pre_clr_s = !is_counting(state_r) || (state_next_s != state_r);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr_s),
        .en   (cnt_en_s),
        .tick (tick_s)
    );

    // Next-state, sweep bookkeeping and datapath control decode
    always_comb begin
        state_next_s = state_r;
        mode_next_s  = mode_r;
        left_next_s  = left_r;
        op_s         = OP_ADD;
        c_ld_s       = 1'b0;
        c_clr_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req.start) begin
                    state_next_s = CLEAR;
                    mode_next_s  = req.mode;
                    left_next_s  = (req.sweeps == SWEEP_ZERO) ? SWEEP_ONE : req.sweeps;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR: begin
                c_clr_s = 1'b1;
                if (req.stop) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = UP;
                end
            end
            UP: begin
                op_s = OP_ADD;
                if (tick_s && !m) begin
                    c_ld_s = 1'b1;
                end else begin
                    c_ld_s = 1'b0;
                end
                if (req.stop) begin
                    state_next_s = IDLE;
                end else if (tick_s && m) begin
                    if (!mode_r || (left_r <= SWEEP_ONE)) begin
                        left_next_s  = SWEEP_ZERO;
                        state_next_s = FINISH;
                    end else begin
                        left_next_s  = left_r - SWEEP_ONE;
                        state_next_s = DOWN;
                    end
                end else begin
                    state_next_s = UP;
                end
            end
            DOWN: begin
                op_s = OP_SUB;
                if (tick_s && !z) begin
                    c_ld_s = 1'b1;
                end else begin
                    c_ld_s = 1'b0;
                end
                if (req.stop) begin
                    state_next_s = IDLE;
                end else if (tick_s && z) begin
                    if (left_r <= SWEEP_ONE) begin
                        left_next_s  = SWEEP_ZERO;
                        state_next_s = FINISH;
                    end else begin
                        left_next_s  = left_r - SWEEP_ONE;
                        state_next_s = UP;
                    end
                end else begin
                    state_next_s = DOWN;
                end
            end
            FINISH: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, latched run configuration and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            mode_r  <= 1'b0;
            left_r  <= SWEEP_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dir_r   <= OP_ADD;
        end else begin
            state_r <= state_next_s;
            mode_r  <= mode_next_s;
            left_r  <= left_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == FINISH);
            dir_r   <= (state_next_s == DOWN) ? OP_SUB : OP_ADD;
        end
    end

    assign op       = op_s;
    assign c_ld     = c_ld_s;
    assign c_clr    = c_clr_s;
    assign req.busy = busy_r;
    assign req.done = done_r;
    assign req.dir  = dir_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: two instances (TICK_DIV 1 and 4), each
// driving a small model of the counter datapath that supplies z and m.
module tb_counter_ctrl;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    counter_ctrl_if #(.SWEEP_W(8)) u1 ();
    counter_ctrl_if #(.SWEEP_W(8)) u4 ();

    logic             z1, m1, op1, ld1, clr1;
    logic             z4, m4, op4, ld4, clr4;
    logic [CNT_W-1:0] cnt1 = 16'h5A5A;
    logic [CNT_W-1:0] cnt4 = 16'h5A5A;
    logic [CNT_W-1:0] top1 = 16'hFFFF;
    logic [CNT_W-1:0] top4 = 16'hFFFF;

    counter_ctrl #(.TICK_DIV(1), .SWEEP_W(8)) dut1 (
        .clk(clk), .rst(rst), .req(u1), .z(z1), .m(m1), .op(op1), .c_ld(ld1), .c_clr(clr1)
    );
    counter_ctrl #(.TICK_DIV(4), .SWEEP_W(8)) dut4 (
        .clk(clk), .rst(rst), .req(u4), .z(z4), .m(m4), .op(op4), .c_ld(ld4), .c_clr(clr4)
    );

    // Datapath models; top is lowered in some runs to shorten sweeps
    always @(posedge clk) begin
        if (clr1) cnt1 <= 16'h0000;
        else if (ld1) cnt1 <= (op1 == OP_SUB) ? cnt1 - 16'h0001 : cnt1 + 16'h0001;
        if (clr4) cnt4 <= 16'h0000;
        else if (ld4) cnt4 <= (op4 == OP_SUB) ? cnt4 - 16'h0001 : cnt4 + 16'h0001;
    end
    assign z1 = (cnt1 == 16'h0000);
    assign m1 = (cnt1 == top1);
    assign z4 = (cnt4 == 16'h0000);
    assign m4 = (cnt4 == top4);

    int n_checks = 0;
    int n_errors = 0;
    int n_busy, n_ld, n_clr, n_done, n_dirsw, n_dirop, done_at, n_bad, c0;
    logic prev_dir;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    // Pulse start on dut1 for one cycle; returns at the negedge of the CLEAR cycle
    task automatic start_run(input logic md, input logic [7:0] sw, input logic with_stop);
        @(negedge clk);
        u1.start = 1'b1; u1.mode = md; u1.sweeps = sw; u1.stop = with_stop;
        @(negedge clk);
        u1.start = 1'b0; u1.stop = 1'b0;
    endtask

    // Sample dut1 every negedge until busy drops, accumulating run statistics
    task automatic run_to_idle(input int max_cyc);
        n_busy = 0; n_ld = 0; n_clr = 0; n_done = 0; n_dirsw = 0; n_dirop = 0;
        done_at = 0; prev_dir = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!u1.busy) break;
            n_busy++;
            if (ld1) n_ld++;
            if (clr1) n_clr++;
            if (u1.done) begin n_done++; done_at = n_busy; end
            if (u1.dir != prev_dir) n_dirsw++;
            if (u1.dir != op1) n_dirop++;
            prev_dir = u1.dir;
            @(negedge clk);
        end
        check_val("run_timeout", 32'(u1.busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u1.start = 1'b0; u1.stop = 1'b0; u1.mode = 1'b0; u1.sweeps = 8'd0;
        u4.start = 1'b0; u4.stop = 1'b0; u4.mode = 1'b0; u4.sweeps = 8'd0;
`ifdef PAUSE_EN
        u1.pause = 1'b0; u4.pause = 1'b0;
`endif
        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_busy",  32'(u1.busy), 32'd0);
        check_val("rst_done",  32'(u1.done), 32'd0);
        check_val("rst_dir",   32'(u1.dir),  32'd0);
        check_val("rst_op",    32'(op1),     32'd0);
        check_val("rst_ld",    32'(ld1),     32'd0);
        check_val("rst_clr",   32'(clr1),    32'd0);
        check_val("rst_busy4", 32'(u4.busy), 32'd0);
        check_val("rst_ld4",   32'(ld4),     32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full 16-bit single up-sweep
        top1 = 16'hFFFF;
        start_run(1'b0, 8'd5, 1'b0);
        check_val("t1_clr", 32'(clr1), 32'd1);
        run_to_idle(70000);
        check_val("t1_len",     32'(n_busy),  32'd65538);
        check_val("t1_loads",   32'(n_ld),    32'd65535);
        check_val("t1_clrs",    32'(n_clr),   32'd1);
        check_val("t1_done",    32'(n_done),  32'd1);
        check_val("t1_done_at", 32'(done_at), 32'd65538);
        check_val("t1_dirsw",   32'(n_dirsw), 32'd0);
        check_val("t1_final",   32'(cnt1),    32'h0000FFFF);
        check_val("t1_done_lo", 32'(u1.done), 32'd0);

        // Bounce, three half-sweeps on a shortened datapath (top 0xFF)
        top1 = 16'h00FF;
        start_run(1'b1, 8'd3, 1'b0);
        run_to_idle(2000);
        check_val("t2_len",     32'(n_busy),  32'd770);
        check_val("t2_loads",   32'(n_ld),    32'd765);
        check_val("t2_dirsw",   32'(n_dirsw), 32'd2);
        check_val("t2_dirop",   32'(n_dirop), 32'd0);
        check_val("t2_done_at", 32'(done_at), 32'd770);
        check_val("t2_final",   32'(cnt1),    32'h000000FF);

        // start+stop together, start while busy, sweeps=0 in bounce mode
        start_run(1'b1, 8'd0, 1'b1);
        check_val("t5_busy", 32'(u1.busy), 32'd1);
        check_val("t5_clr",  32'(clr1),    32'd1);
        u1.start = 1'b1; u1.sweeps = 8'd2;
        @(negedge clk);
        u1.start = 1'b0;
        run_to_idle(2000);
        check_val("t5_len",   32'(n_busy),  32'd257);
        check_val("t5_clrs",  32'(n_clr),   32'd0);
        check_val("t5_loads", 32'(n_ld),    32'd255);
        check_val("t5_dirsw", 32'(n_dirsw), 32'd0);
        check_val("t5_done",  32'(n_done),  32'd1);
        check_val("t5_final", 32'(cnt1),    32'h000000FF);

        // Reset while counting down at 100, then a fresh run re-clears
        top1 = 16'd200;
        start_run(1'b1, 8'd2, 1'b0);
        for (int i = 0; i < 1000 && !(op1 == OP_SUB && cnt1 == 16'd100); i++) @(negedge clk);
        check_val("t4_reach", 32'(cnt1),   32'd100);
        check_val("t4_dir",   32'(u1.dir), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t4_busy", 32'(u1.busy), 32'd0);
        check_val("t4_done", 32'(u1.done), 32'd0);
        check_val("t4_dir0", 32'(u1.dir),  32'd0);
        check_val("t4_op",   32'(op1),     32'd0);
        check_val("t4_ld",   32'(ld1),     32'd0);
        check_val("t4_clr",  32'(clr1),    32'd0);
        check_val("t4_hold", 32'(cnt1),    32'd99);
        start_run(1'b0, 8'd0, 1'b0);
        check_val("t4_reclr", 32'(clr1), 32'd1);
        @(negedge clk);
        check_val("t4_zero", 32'(cnt1), 32'd0);
        run_to_idle(1000);
        check_val("t4_len",   32'(n_busy), 32'd202);
        check_val("t4_final", 32'(cnt1),   32'd200);
        check_val("t4_done2", 32'(n_done), 32'd1);

        // TICK_DIV=4: stop during cycle 50 after start
        @(negedge clk);
        u4.start = 1'b1; u4.mode = 1'b0; u4.sweeps = 8'd0;
        n_ld = 0; n_bad = 0; n_done = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            u4.start = 1'b0;
            if (ld4) begin
                n_ld++;
                if ((c % 4) != 1) n_bad++;
            end
            if (u4.done) n_done++;
        end
        check_val("t3_busy_pre", 32'(u4.busy), 32'd1);
        u4.stop = 1'b1;
        @(negedge clk);
        u4.stop = 1'b0;
        check_val("t3_busy",  32'(u4.busy), 32'd0);
        check_val("t3_done",  32'(u4.done), 32'd0);
        check_val("t3_ld",    32'(ld4),     32'd0);
        check_val("t3_count", 32'(cnt4),    32'd12);
        check_val("t3_loads", 32'(n_ld),    32'd12);
        check_val("t3_phase", 32'(n_bad),   32'd0);
        check_val("t3_ndone", 32'(n_done),  32'd0);
        repeat (3) @(negedge clk);
        check_val("t3_hold",  32'(cnt4),    32'd12);

`ifdef PAUSE_EN
        // Pause for ten cycles at count 20
        top1 = 16'h00FF;
        start_run(1'b0, 8'd1, 1'b0);
        c0 = cyc;
        for (int i = 0; i < 100 && cnt1 != 16'd20; i++) @(negedge clk);
        check_val("t6_reach", 32'(cnt1), 32'd20);
        u1.pause = 1'b1;
        repeat (10) @(negedge clk);
        check_val("t6_hold", 32'(cnt1),    32'd20);
        check_val("t6_busy", 32'(u1.busy), 32'd1);
        u1.pause = 1'b0;
        @(negedge clk);
        check_val("t6_resume", 32'(cnt1), 32'd21);
        run_to_idle(1000);
        check_val("t6_len",   32'(cyc - c0), 32'd268);
        check_val("t6_final", 32'(cnt1),     32'h000000FF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
